// File: rtl/signal_phase_controller.sv
// Phase sequencer for the signal-timer/distance subtractor: generates the
// seconds tick, loads phase durations and cycles GREEN -> YELLOW -> RED.
module signal_phase_controller #(
    parameter int TICK_DIV    = 50000000,
    parameter int GREEN_TIME  = 30,
    parameter int YELLOW_TIME = 5,
    parameter int RED_TIME    = 25
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       hold,
    input  logic       signal_switch,
    input  logic       signal_reached,
    output logic       seconds_tick,
    output logic       valid_data,
    output logic       sub_enable,
    output logic [5:0] data_in,
    output logic [2:0] light,
    output logic       phase_done,
    output logic       vehicle_warn,
    output logic [7:0] cycle_count
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_COUNT  = 2'd2;
    localparam logic [1:0] S_SWITCH = 2'd3;

    localparam logic [1:0] P_GREEN  = 2'd0;
    localparam logic [1:0] P_YELLOW = 2'd1;
    localparam logic [1:0] P_RED    = 2'd2;

    logic [1:0]    r_state, w_state_nxt;
    logic [1:0]    r_phase, w_phase_nxt;
    logic [CW-1:0] r_tick_cnt, w_tick_cnt_nxt;
    logic [7:0]    r_cycle_cnt, w_cycle_cnt_nxt;
    logic          w_running;

    // Hold gates both the prescaler and the exit from COUNT.
    assign w_running = (r_state == S_COUNT) && !hold;

    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_tick_cnt_nxt  = r_tick_cnt;
        w_cycle_cnt_nxt = r_cycle_cnt;
        if (!enable) begin
            w_state_nxt    = S_IDLE;
            w_phase_nxt    = P_GREEN;
            w_tick_cnt_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_LOAD;
                S_LOAD: begin
                    w_tick_cnt_nxt = '0;
                    w_state_nxt    = S_COUNT;
                end
                S_COUNT: begin
                    if (!hold) begin
                        w_tick_cnt_nxt = (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + CW'(1);
                        if (signal_switch) w_state_nxt = S_SWITCH;
                    end
                end
                default: begin
                    w_state_nxt = S_LOAD;
                    case (r_phase)
                        P_GREEN:  w_phase_nxt = P_YELLOW;
                        P_YELLOW: w_phase_nxt = P_RED;
                        default: begin
                            w_phase_nxt     = P_GREEN;
                            w_cycle_cnt_nxt = r_cycle_cnt + 8'd1;
                        end
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_phase     <= P_GREEN;
            r_tick_cnt  <= '0;
            r_cycle_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_tick_cnt  <= w_tick_cnt_nxt;
            r_cycle_cnt <= w_cycle_cnt_nxt;
        end
    end

    assign seconds_tick = w_running && (r_tick_cnt == TICK_LAST);
    assign valid_data   = (r_state == S_LOAD);
    assign sub_enable   = (r_state == S_LOAD) || w_running;
    assign phase_done   = (r_state == S_SWITCH);
    assign vehicle_warn = signal_reached && (r_state == S_COUNT) && (r_phase != P_GREEN);
    assign cycle_count  = r_cycle_cnt;

    always_comb begin
        case (r_phase)
            P_YELLOW: data_in = 6'(YELLOW_TIME);
            P_RED:    data_in = 6'(RED_TIME);
            default:  data_in = 6'(GREEN_TIME);
        endcase
    end

    // IDLE shows red regardless of the phase register.
    always_comb begin
        if (r_state == S_IDLE) light = 3'b100;
        else begin
            case (r_phase)
                P_YELLOW: light = 3'b010;
                P_RED:    light = 3'b100;
                default:  light = 3'b001;
            endcase
        end
    end

endmodule

// File: tb/tb_signal_phase_controller.sv
// Directed bench for signal_phase_controller with a small behavioural
// subtractor that answers signal_switch from the loaded duration.
module tb_signal_phase_controller;

    logic       clock, reset, enable, hold, signal_switch, signal_reached;
    logic       seconds_tick, valid_data, sub_enable, phase_done, vehicle_warn;
    logic [5:0] data_in;
    logic [2:0] light;
    logic [7:0] cycle_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    signal_phase_controller #(
        .TICK_DIV(4), .GREEN_TIME(3), .YELLOW_TIME(2), .RED_TIME(2)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .hold(hold),
        .signal_switch(signal_switch), .signal_reached(signal_reached),
        .seconds_tick(seconds_tick), .valid_data(valid_data), .sub_enable(sub_enable),
        .data_in(data_in), .light(light), .phase_done(phase_done),
        .vehicle_warn(vehicle_warn), .cycle_count(cycle_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Subtractor stand-in: loads on valid_data, counts down on enabled ticks.
    logic [5:0] sub_tmr;
    always @(posedge clock or negedge reset) begin
        if (!reset) sub_tmr <= '0;
        else if (valid_data) sub_tmr <= data_in;
        else if (seconds_tick && sub_enable && sub_tmr != 0) sub_tmr <= sub_tmr - 6'd1;
    end
    assign signal_switch = (sub_tmr == 6'd0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; hold = 1'b0; signal_reached = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_light", 32'(light), 'b100);
        chk("rst_data", 32'(data_in), 3);
        chk("rst_valid", 32'(valid_data), 0);
        chk("rst_tick", 32'(seconds_tick), 0);
        chk("rst_suben", 32'(sub_enable), 0);
        chk("rst_done", 32'(phase_done), 0);
        chk("rst_warn", 32'(vehicle_warn), 0);
        chk("rst_cc", 32'(cycle_count), 0);

        // Cycle 0: reset released, enable high, still IDLE.
        reset = 1'b1; enable = 1'b1; cyc = 0;
        #1 chk("idle_light", 32'(light), 'b100);
        step();
        chk("load_valid", 32'(valid_data), 1);
        chk("load_data", 32'(data_in), 3);
        chk("load_light", 32'(light), 'b001);
        chk("load_suben", 32'(sub_enable), 1);

        for (int c = 2; c <= 38; c++) begin
            step();
            chk("tick", 32'(seconds_tick), 32'(cyc inside {5, 9, 13, 20, 24, 31, 35}));
            chk("valid", 32'(valid_data), 32'(cyc inside {16, 27, 38}));
            chk("done", 32'(phase_done), 32'(cyc inside {15, 26, 37}));
            chk("suben", 32'(sub_enable), 32'(!(cyc inside {15, 26, 37})));
            chk("light", 32'(light), (cyc <= 15 || cyc == 38) ? 'b001 : (cyc <= 26) ? 'b010 : 'b100);
            chk("data", 32'(data_in), (cyc <= 15 || cyc == 38) ? 3 : 2);
            chk("cc", 32'(cycle_count), (cyc == 38) ? 1 : 0);
        end

        // Green warning suppressed.
        run_to(45);
        signal_reached = 1'b1;
        #1 chk("warn_green", 32'(vehicle_warn), 0);
        signal_reached = 1'b0;

        // Hold high over the edges ending cycles 49..58.
        run_to(49);
        hold = 1'b1;
        #1 chk("hold_suben49", 32'(sub_enable), 0);
        for (int c = 50; c <= 58; c++) begin
            step();
            chk("hold_tick", 32'(seconds_tick), 0);
            chk("hold_suben", 32'(sub_enable), 0);
            chk("hold_light", 32'(light), 'b001);
        end
        step();
        hold = 1'b0;
        #1 chk("unhold_suben", 32'(sub_enable), 1);
        step(); chk("hold_tick60", 32'(seconds_tick), 1);
        step(); chk("hold_done61", 32'(phase_done), 0);
        step(); chk("hold_done62", 32'(phase_done), 1);
                chk("hold_valid62", 32'(valid_data), 0);
        step(); chk("hold_valid63", 32'(valid_data), 1);
                chk("hold_light63", 32'(light), 'b010);

        // Yellow: warning, then hold while signal_switch is already high.
        run_to(65);
        signal_reached = 1'b1;
        #1 chk("warn_yellow", 32'(vehicle_warn), 1);
        signal_reached = 1'b0;
        #1 chk("warn_clear", 32'(vehicle_warn), 0);
        run_to(71); chk("y_tick71", 32'(seconds_tick), 1);
        step();
        chk("y_sw72", 32'(signal_switch), 1);
        chk("y_done72", 32'(phase_done), 0);
        hold = 1'b1;
        #1 chk("y_hold_suben", 32'(sub_enable), 0);
        for (int c = 73; c <= 75; c++) begin
            step();
            chk("y_hold_done", 32'(phase_done), 0);
            chk("y_hold_light", 32'(light), 'b010);
            chk("y_hold_valid", 32'(valid_data), 0);
        end
        hold = 1'b0;
        #1 chk("y_unhold_suben", 32'(sub_enable), 1);
        step(); chk("y_done76", 32'(phase_done), 1);
        step(); chk("r_valid77", 32'(valid_data), 1);
                chk("r_light77", 32'(light), 'b100);
                chk("r_data77", 32'(data_in), 2);

        // Async reset between edges in red COUNT.
        run_to(80);
        chk("pre_rst_cc", 32'(cycle_count), 1);
        chk("pre_rst_suben", 32'(sub_enable), 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_light", 32'(light), 'b100);
        chk("arst_data", 32'(data_in), 3);
        chk("arst_suben", 32'(sub_enable), 0);
        chk("arst_cc", 32'(cycle_count), 0);
        chk("arst_valid", 32'(valid_data), 0);
        step(); step();
        chk("arst_hold_light", 32'(light), 'b100);
        reset = 1'b1; cyc = 0;
        step();
        chk("rel_valid", 32'(valid_data), 1);
        chk("rel_data", 32'(data_in), 3);
        chk("rel_light", 32'(light), 'b001);

        // 256 full cycles of 37 clocks each.
        run_to(9435); chk("cc_254", 32'(cycle_count), 254);
        run_to(9436); chk("cc_255", 32'(cycle_count), 255);
        run_to(9472); chk("cc_255b", 32'(cycle_count), 255);
        run_to(9473);
        chk("cc_wrap", 32'(cycle_count), 0);
        chk("wrap_valid", 32'(valid_data), 1);
        chk("wrap_light", 32'(light), 'b001);

        // Disable mid-yellow, then restart.
        run_to(9490);
        chk("dis_pre_light", 32'(light), 'b010);
        enable = 1'b0;
        step();
        chk("dis_light", 32'(light), 'b100);
        chk("dis_data", 32'(data_in), 3);
        chk("dis_suben", 32'(sub_enable), 0);
        chk("dis_valid", 32'(valid_data), 0);
        step();
        chk("dis_valid2", 32'(valid_data), 0);
        enable = 1'b1;
        step();
        chk("reen_valid", 32'(valid_data), 1);
        chk("reen_data", 32'(data_in), 3);
        chk("reen_light", 32'(light), 'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
